uart_bridge_fifo: RTL and testbench



---
 rtl/uart_bridge_fifo.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_uart_bridge_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bridge_fifo.sv
// Memory-mapped UART bridge with TX/RX FIFOs, runtime frame format (5..8 data bits,
// optional parity, 1/2 stop bits), sticky error flags and a level interrupt.
module uart_bridge_fifo #(
  parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
  parameter int          TX_DEPTH       = 8,
  parameter int          RX_DEPTH       = 8,
  parameter logic [31:0] DEFAULT_CLKDIV = 32'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_valid,
  output logic        uart_ready,
  input  logic [3:0]  uart_wstrb,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  output logic [31:0] uart_rdata,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic        irq
);

  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int RXAW = $clog2(RX_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} frameState_e;

  // Bus decode
  logic        ready_q;
  logic [31:0] rdata_q;
  logic        accept, isWrite;
  logic [31:0] addrOff;
  logic        selTx, selRx, selCfg, selDiv, selStat;

  assign accept  = uart_valid & ~ready_q;
  assign isWrite = |uart_wstrb;
  assign addrOff = uart_addr - BASE_ADDR;
  assign selTx   = (addrOff == 32'h00);
  assign selRx   = (addrOff == 32'h04);
  assign selCfg  = (addrOff == 32'h08);
  assign selDiv  = (addrOff == 32'h0C);
  assign selStat = (addrOff == 32'h10);

  logic [7:0]  cfg_q, cfg_d;
  logic [31:0] clkdiv_q, clkdiv_d;
  logic        txOvf_q, txOvf_d, rxOvf_q, rxOvf_d;
  logic        ferrSeen_q, ferrSeen_d, perrSeen_q, perrSeen_d;
  logic [31:0] readValue, statusWord;

  // TX FIFO
  logic [7:0]      txMem [TX_DEPTH];
  logic [TXAW-1:0] txWr_q, txRd_q;
  logic [TXAW:0]   txCount_q;
  logic            txFull, txEmpty, txPushReq, txPush, txPop;
  logic [7:0]      txHead;

  assign txFull    = (txCount_q == (TXAW+1)'(TX_DEPTH));
  assign txEmpty   = (txCount_q == '0);
  assign txPushReq = accept & isWrite & selTx;
  assign txPush    = txPushReq & (~txFull | txPop);
  assign txHead    = txMem[txRd_q];

  // RX FIFO
  logic [10:0]     rxMem [RX_DEPTH];
  logic [RXAW-1:0] rxWr_q, rxRd_q;
  logic [RXAW:0]   rxCount_q;
  logic            rxFull, rxEmpty, rxPushReq, rxPush, rxPop;
  logic [10:0]     rxEntry;

  assign rxFull  = (rxCount_q == (RXAW+1)'(RX_DEPTH));
  assign rxEmpty = (rxCount_q == '0);
  assign rxPop   = accept & ~isWrite & selRx & ~rxEmpty;
  assign rxPush  = rxPushReq & (~rxFull | rxPop);

  always_ff @(posedge clk) begin
    if (txPush) txMem[txWr_q] <= uart_wdata[7:0];
    if (rxPush) rxMem[rxWr_q] <= rxEntry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txWr_q <= '0; txRd_q <= '0; txCount_q <= '0;
      rxWr_q <= '0; rxRd_q <= '0; rxCount_q <= '0;
    end else begin
      if (txPush) txWr_q <= txWr_q + TXAW'(1);
      if (txPop)  txRd_q <= txRd_q + TXAW'(1);
      if (txPush && !txPop) txCount_q <= txCount_q + (TXAW+1)'(1);
      else if (!txPush && txPop) txCount_q <= txCount_q - (TXAW+1)'(1);
      if (rxPush) rxWr_q <= rxWr_q + RXAW'(1);
      if (rxPop)  rxRd_q <= rxRd_q + RXAW'(1);
      if (rxPush && !rxPop) rxCount_q <= rxCount_q + (RXAW+1)'(1);
      else if (!rxPush && rxPop) rxCount_q <= rxCount_q - (RXAW+1)'(1);
    end
  end

  // TX frame state
  frameState_e txState_q, txState_d;
  logic [31:0] txCnt_q, txCnt_d, txDiv_q, txDiv_d;
  logic [7:0]  txShift_q, txShift_d, txMask;
  logic [2:0]  txBitIdx_q, txBitIdx_d, txLast_q, txLast_d;
  logic        txPen_q, txPen_d, txStop2_q, txStop2_d, txStop2nd_q, txStop2nd_d;
  logic        txParity_q, txParity_d, serTx_q, serTx_d, txLoad;

  assign txMask = 8'hFF >> (2'd3 - cfg_q[1:0]);

  always_comb begin
    txState_d = txState_q; txCnt_d = txCnt_q; txDiv_d = txDiv_q;
    txShift_d = txShift_q; txBitIdx_d = txBitIdx_q; txLast_d = txLast_q;
    txPen_d = txPen_q; txStop2_d = txStop2_q; txStop2nd_d = txStop2nd_q;
    txParity_d = txParity_q; serTx_d = serTx_q;
    txLoad = 1'b0;
    txPop  = 1'b0;
    case (txState_q)
      S_IDLE: if (!txEmpty) txLoad = 1'b1;
      S_START:
        if (txCnt_q == txDiv_q) begin
          txCnt_d = '0; txState_d = S_DATA; txBitIdx_d = '0; serTx_d = txShift_q[0];
        end else txCnt_d = txCnt_q + 32'd1;
      S_DATA:
        if (txCnt_q == txDiv_q) begin
          txCnt_d = '0;
          if (txBitIdx_q == txLast_q) begin
            if (txPen_q) begin
              txState_d = S_PARITY; serTx_d = txParity_q;
            end else begin
              txState_d = S_STOP; serTx_d = 1'b1; txStop2nd_d = 1'b0;
            end
          end else begin
            txBitIdx_d = txBitIdx_q + 3'd1;
            serTx_d    = txShift_q[txBitIdx_q + 3'd1];
          end
        end else txCnt_d = txCnt_q + 32'd1;
      S_PARITY:
        if (txCnt_q == txDiv_q) begin
          txCnt_d = '0; txState_d = S_STOP; serTx_d = 1'b1; txStop2nd_d = 1'b0;
        end else txCnt_d = txCnt_q + 32'd1;
      S_STOP:
        if (txCnt_q == txDiv_q) begin
          txCnt_d = '0;
          if (txStop2_q && !txStop2nd_q) txStop2nd_d = 1'b1;
          else if (!txEmpty) txLoad = 1'b1;
          else begin
            txState_d = S_IDLE; serTx_d = 1'b1;
          end
        end else txCnt_d = txCnt_q + 32'd1;
      default: begin
        txState_d = S_IDLE; serTx_d = 1'b1;
      end
    endcase
    // Frame start: format and divider are frozen here for the whole frame
    if (txLoad) begin
      txPop      = 1'b1;
      txShift_d  = txHead;
      txLast_d   = {1'b0, cfg_q[1:0]} + 3'd4;
      txPen_d    = cfg_q[2];
      txStop2_d  = cfg_q[4];
      txParity_d = (^(txHead & txMask)) ^ cfg_q[3];
      txDiv_d    = clkdiv_q;
      txCnt_d    = '0;
      txState_d  = S_START;
      serTx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txState_q <= S_IDLE; txCnt_q <= '0; txDiv_q <= '0; txShift_q <= '0;
      txBitIdx_q <= '0; txLast_q <= '0; txPen_q <= 1'b0; txStop2_q <= 1'b0;
      txStop2nd_q <= 1'b0; txParity_q <= 1'b0; serTx_q <= 1'b1;
    end else begin
      txState_q <= txState_d; txCnt_q <= txCnt_d; txDiv_q <= txDiv_d; txShift_q <= txShift_d;
      txBitIdx_q <= txBitIdx_d; txLast_q <= txLast_d; txPen_q <= txPen_d; txStop2_q <= txStop2_d;
      txStop2nd_q <= txStop2nd_d; txParity_q <= txParity_d; serTx_q <= serTx_d;
    end
  end

  // RX frame state
  frameState_e rxState_q, rxState_d;
  logic [31:0] rxCnt_q, rxCnt_d, rxDiv_q, rxDiv_d, rxHalf;
  logic [7:0]  rxData_q, rxData_d;
  logic [2:0]  rxBitIdx_q, rxBitIdx_d, rxLast_q, rxLast_d;
  logic        rxPen_q, rxPen_d, rxPodd_q, rxPodd_d, rxPerr_q, rxPerr_d;
  logic        rxSync1_q, rxSync2_q, rxPrev_q, rxFall, rxFerr;

  assign rxFall = rxPrev_q & ~rxSync2_q;
  assign rxHalf = (rxDiv_q + 32'd1) >> 1;

  always_comb begin
    rxState_d = rxState_q; rxCnt_d = rxCnt_q; rxDiv_d = rxDiv_q; rxData_d = rxData_q;
    rxBitIdx_d = rxBitIdx_q; rxLast_d = rxLast_q; rxPen_d = rxPen_q;
    rxPodd_d = rxPodd_q; rxPerr_d = rxPerr_q;
    rxPushReq = 1'b0;
    rxFerr    = 1'b0;
    rxEntry   = '0;
    case (rxState_q)
      S_IDLE:
        if (rxFall) begin
          rxState_d = S_START; rxCnt_d = '0; rxDiv_d = clkdiv_q; rxData_d = '0;
          rxBitIdx_d = '0; rxLast_d = {1'b0, cfg_q[1:0]} + 3'd4;
          rxPen_d = cfg_q[2]; rxPodd_d = cfg_q[3]; rxPerr_d = 1'b0;
        end
      S_START:
        if (rxCnt_q == rxHalf) begin
          rxCnt_d   = '0;
          rxState_d = rxSync2_q ? S_IDLE : S_DATA;
        end else rxCnt_d = rxCnt_q + 32'd1;
      S_DATA:
        if (rxCnt_q == rxDiv_q) begin
          rxCnt_d = '0;
          rxData_d[rxBitIdx_q] = rxSync2_q;
          if (rxBitIdx_q == rxLast_q) rxState_d = rxPen_q ? S_PARITY : S_STOP;
          else rxBitIdx_d = rxBitIdx_q + 3'd1;
        end else rxCnt_d = rxCnt_q + 32'd1;
      S_PARITY:
        if (rxCnt_q == rxDiv_q) begin
          rxCnt_d   = '0;
          rxPerr_d  = rxSync2_q ^ (^rxData_q) ^ rxPodd_q;
          rxState_d = S_STOP;
        end else rxCnt_d = rxCnt_q + 32'd1;
      S_STOP:
        if (rxCnt_q == rxDiv_q) begin
          rxCnt_d   = '0;
          rxFerr    = ~rxSync2_q;
          rxPushReq = 1'b1;
          rxEntry   = {(rxData_q == 8'h00) & rxFerr, rxPerr_q, rxFerr, rxData_q};
          rxState_d = S_IDLE;
        end else rxCnt_d = rxCnt_q + 32'd1;
      default: rxState_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxState_q <= S_IDLE; rxCnt_q <= '0; rxDiv_q <= '0; rxData_q <= '0;
      rxBitIdx_q <= '0; rxLast_q <= '0; rxPen_q <= 1'b0; rxPodd_q <= 1'b0; rxPerr_q <= 1'b0;
      rxSync1_q <= 1'b1; rxSync2_q <= 1'b1; rxPrev_q <= 1'b1;
    end else begin
      rxState_q <= rxState_d; rxCnt_q <= rxCnt_d; rxDiv_q <= rxDiv_d; rxData_q <= rxData_d;
      rxBitIdx_q <= rxBitIdx_d; rxLast_q <= rxLast_d; rxPen_q <= rxPen_d; rxPodd_q <= rxPodd_d;
      rxPerr_q <= rxPerr_d;
      rxSync1_q <= cfg_q[7] ? serTx_q : ser_rx;
      rxSync2_q <= rxSync1_q;
      rxPrev_q  <= rxSync2_q;
    end
  end

  assign statusWord = {10'b0, perrSeen_q, ferrSeen_q, rxOvf_q, txOvf_q,
                       (rxState_q != S_IDLE), (txState_q != S_IDLE),
                       8'(rxCount_q), 8'(txCount_q)};

  // Register file; set events are applied after W1C so a coincident set wins
  always_comb begin
    cfg_d = cfg_q; clkdiv_d = clkdiv_q;
    txOvf_d = txOvf_q; rxOvf_d = rxOvf_q; ferrSeen_d = ferrSeen_q; perrSeen_d = perrSeen_q;
    readValue = '0;
    if (accept && isWrite) begin
      if (selCfg) cfg_d = uart_wdata[7:0];
      if (selDiv) clkdiv_d = (uart_wdata < 32'd3) ? 32'd3 : uart_wdata;
      if (selStat) begin
        if (uart_wdata[18]) txOvf_d    = 1'b0;
        if (uart_wdata[19]) rxOvf_d    = 1'b0;
        if (uart_wdata[20]) ferrSeen_d = 1'b0;
        if (uart_wdata[21]) perrSeen_d = 1'b0;
      end
    end
    if (txPushReq && !txPush) txOvf_d    = 1'b1;
    if (rxPushReq && !rxPush) rxOvf_d    = 1'b1;
    if (rxPushReq && rxFerr)  ferrSeen_d = 1'b1;
    if (rxPushReq && rxPerr_q) perrSeen_d = 1'b1;
    if (!isWrite) begin
      if (selRx)        readValue = rxEmpty ? 32'h8000_0000 : {21'b0, rxMem[rxRd_q]};
      else if (selCfg)  readValue = {24'b0, cfg_q};
      else if (selDiv)  readValue = clkdiv_q;
      else if (selStat) readValue = statusWord;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0; rdata_q <= '0;
      cfg_q <= 8'h03; clkdiv_q <= DEFAULT_CLKDIV;
      txOvf_q <= 1'b0; rxOvf_q <= 1'b0; ferrSeen_q <= 1'b0; perrSeen_q <= 1'b0;
    end else begin
      ready_q <= accept;
      rdata_q <= accept ? readValue : 32'h0;
      cfg_q <= cfg_d; clkdiv_q <= clkdiv_d;
      txOvf_q <= txOvf_d; rxOvf_q <= rxOvf_d; ferrSeen_q <= ferrSeen_d; perrSeen_q <= perrSeen_d;
    end
  end

  assign uart_ready = ready_q;
  assign uart_rdata = rdata_q;
  assign ser_tx     = serTx_q;
  assign irq        = (~rxEmpty & cfg_q[5]) | (txEmpty & cfg_q[6]);

endmodule

// File: tb/tb_uart_bridge_fifo.sv
// Scoreboard bench for uart_bridge_fifo: a line monitor decodes ser_tx frames against
// queued TX bytes, and RXDATA reads are compared against queued receive results.
module tb_uart_bridge_fifo;

  localparam logic [31:0] BASE    = 32'h4000_0000;
  localparam logic [31:0] A_TX    = BASE + 32'h00;
  localparam logic [31:0] A_RX    = BASE + 32'h04;
  localparam logic [31:0] A_CFG   = BASE + 32'h08;
  localparam logic [31:0] A_DIV   = BASE + 32'h0C;
  localparam logic [31:0] A_STAT  = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_valid = 1'b0;
  logic        uart_ready;
  logic [3:0]  uart_wstrb = 4'h0;
  logic [31:0] uart_addr = 32'h0;
  logic [31:0] uart_wdata = 32'h0;
  logic [31:0] uart_rdata;
  logic        ser_rx = 1'b1;
  logic        ser_tx;
  logic        irq;

  always #5 clk = ~clk;

  uart_bridge_fifo #(
    .BASE_ADDR(BASE), .TX_DEPTH(8), .RX_DEPTH(8), .DEFAULT_CLKDIV(32'd867)
  ) dut (
    .clk(clk), .reset(reset), .uart_valid(uart_valid), .uart_ready(uart_ready),
    .uart_wstrb(uart_wstrb), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_rdata(uart_rdata), .ser_rx(ser_rx), .ser_tx(ser_tx), .irq(irq)
  );

  int checksTotal = 0;
  int checksPassed = 0;
  logic [7:0]  txExpQ[$];
  logic [31:0] rxExpQ[$];
  int monDiv = 3;
  int monBits = 8;
  bit monPen = 1'b0;
  bit monPodd = 1'b0;
  bit monStop2 = 1'b0;
  bit monEnable = 1'b0;
  bit monBusy = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    else
      checksPassed++;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, output logic [31:0] rdata);
    int n;
    @(negedge clk);
    uart_valid = 1'b1; uart_addr = addr; uart_wdata = wdata; uart_wstrb = strb;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!uart_ready && n < 8);
    if (!uart_ready) checkOutput("bus_ack", {31'b0, uart_ready}, 32'h1);
    rdata = uart_rdata;
    uart_valid = 1'b0; uart_wstrb = 4'h0;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    applyStimulus(addr, data, 4'hF, dummy);
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    applyStimulus(addr, 32'h0, 4'h0, data);
  endtask

  task automatic waitTxDrain(input int limit);
    for (int i = 0; i < limit && (txExpQ.size() != 0 || monBusy); i++) @(posedge clk);
    checkOutput("tx_drain", txExpQ.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic readRxAndCheck(input string tag);
    logic [31:0] st, v, exp;
    int n;
    n = 0;
    do begin
      busRead(A_STAT, st); n++;
    end while (st[15:8] == 8'h00 && n < 300);
    busRead(A_RX, v);
    exp = (rxExpQ.size() != 0) ? rxExpQ.pop_front() : 32'h8000_0000;
    checkOutput(tag, v, exp);
  endtask

  task automatic holdRx(input logic v, input int div);
    ser_rx = v;
    repeat (div + 1) @(negedge clk);
  endtask

  task automatic driveRxFrame(input logic [7:0] data, input bit hasPar, input bit parBit,
                              input bit stopVal, input int div);
    @(negedge clk);
    holdRx(1'b0, div);
    for (int i = 0; i < 8; i++) holdRx(data[i], div);
    if (hasPar) holdRx(parBit, div);
    holdRx(stopVal, div);
    ser_rx = 1'b1;
    repeat (2 * (div + 1)) @(negedge clk);
  endtask

  // Serial line monitor: every bit period must be constant for monDiv+1 clocks
  initial begin
    logic [11:0] got;
    logic [7:0]  gotData, exp, mask;
    bit          clean;
    int          total;
    forever begin
      @(negedge clk);
      if (monEnable && !reset && ser_tx === 1'b0) begin
        monBusy = 1'b1;
        clean = 1'b1;
        got = '0;
        total = 2 + monBits + int'(monPen) + int'(monStop2);
        for (int b = 0; b < total; b++) begin
          for (int c = 0; c <= monDiv; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (c == 0) got[b] = ser_tx;
            else if (ser_tx !== got[b]) clean = 1'b0;
          end
        end
        gotData = '0;
        for (int i = 0; i < monBits; i++) gotData[i] = got[1 + i];
        mask = 8'((1 << monBits) - 1);
        if (txExpQ.size() == 0) begin
          checkOutput("tx_unexpected_frame", {24'b0, gotData}, 32'hFFFF_FFFF);
        end else begin
          exp = txExpQ.pop_front();
          checkOutput("tx_start", {31'b0, got[0]}, 32'h0);
          checkOutput("tx_data", {24'b0, gotData}, {24'b0, exp & mask});
          if (monPen)
            checkOutput("tx_parity", {31'b0, got[1 + monBits]}, {31'b0, (^(exp & mask)) ^ monPodd});
          checkOutput("tx_stop", {31'b0, got[1 + monBits + int'(monPen)]}, 32'h1);
          checkOutput("tx_bit_timing", {31'b0, clean}, 32'h1);
        end
        monBusy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset state
    checkOutput("reset_ser_tx", {31'b0, ser_tx}, 32'h1);
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    checkOutput("reset_ready", {31'b0, uart_ready}, 32'h0);
    checkOutput("reset_rdata", uart_rdata, 32'h0);
    busRead(A_STAT, v); checkOutput("reset_status", v, 32'h0);
    busRead(A_CFG, v);  checkOutput("reset_config", v, 32'h3);
    busRead(A_DIV, v);  checkOutput("reset_clkdiv", v, 32'h363);

    // CLKDIV floor and basic 8N1 frame of 0xA5
    busWrite(A_DIV, 32'd1);
    busRead(A_DIV, v);  checkOutput("clkdiv_min", v, 32'd3);
    busWrite(A_DIV, 32'd3);
    busWrite(A_CFG, 32'h3);
    monDiv = 3; monBits = 8; monPen = 0; monPodd = 0; monStop2 = 0; monEnable = 1;
    txExpQ.push_back(8'hA5);
    busWrite(A_TX, 32'hA5);
    busRead(A_TX, v);   checkOutput("txdata_read_zero", v, 32'h0);
    waitTxDrain(500);
    busRead(A_STAT, v); checkOutput("tx_busy_after_frame", {31'b0, v[16]}, 32'h0);

    // TX overflow: fill FIFO while a frame is on the line
    txExpQ.push_back(8'h11);
    busWrite(A_TX, 32'h11);
    busRead(A_STAT, v);
    checkOutput("tx_busy_active", {31'b0, v[16]}, 32'h1);
    checkOutput("tx_count_popped", {24'b0, v[7:0]}, 32'h0);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) txExpQ.push_back(8'(8'h20 + i));
      busWrite(A_TX, 32'h20 + i);
    end
    busRead(A_STAT, v);
    checkOutput("tx_count_full", {24'b0, v[7:0]}, 32'd8);
    checkOutput("txovf_set", {31'b0, v[18]}, 32'h1);
    busWrite(A_STAT, 32'h0004_0000);
    busRead(A_STAT, v);
    checkOutput("txovf_cleared", {31'b0, v[18]}, 32'h0);
    waitTxDrain(2000);

    // Loopback 8E1 at CLKDIV=7
    busWrite(A_DIV, 32'd7);
    busWrite(A_CFG, 32'h87);
    monDiv = 7; monPen = 1; monPodd = 0;
    txExpQ.push_back(8'h07);
    rxExpQ.push_back(32'h0000_0007);
    busWrite(A_TX, 32'h07);
    waitTxDrain(500);
    readRxAndCheck("loopback_rxdata");
    busWrite(A_CFG, 32'h3);
    monPen = 0;

    // Empty RX read
    busRead(A_RX, v);   checkOutput("rx_empty_code", v, 32'h8000_0000);

    // External RX frames at CLKDIV=15
    busWrite(A_DIV, 32'd15);
    rxExpQ.push_back(32'h0000_013C);
    driveRxFrame(8'h3C, 1'b0, 1'b0, 1'b0, 15);
    readRxAndCheck("rx_ferr_frame");
    busRead(A_STAT, v); checkOutput("ferr_seen_set", {31'b0, v[20]}, 32'h1);
    busWrite(A_STAT, 32'h0010_0000);
    busRead(A_STAT, v); checkOutput("ferr_seen_cleared", {31'b0, v[20]}, 32'h0);

    rxExpQ.push_back(32'h0000_005A);
    driveRxFrame(8'h5A, 1'b0, 1'b0, 1'b1, 15);
    readRxAndCheck("rx_good_frame");

    busWrite(A_CFG, 32'h07);
    rxExpQ.push_back(32'h0000_0207);
    driveRxFrame(8'h07, 1'b1, 1'b0, 1'b1, 15);
    readRxAndCheck("rx_perr_frame");
    busRead(A_STAT, v); checkOutput("perr_seen_set", {31'b0, v[21]}, 32'h1);

    busWrite(A_CFG, 32'h03);
    rxExpQ.push_back(32'h0000_0500);
    driveRxFrame(8'h00, 1'b0, 1'b0, 1'b0, 15);
    readRxAndCheck("rx_break_frame");

    // Short glitch on the line must not produce an entry
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (3) @(negedge clk);
    ser_rx = 1'b1;
    repeat (40) @(negedge clk);
    busRead(A_STAT, v); checkOutput("glitch_ignored", {22'b0, v[17:8]}, 32'h0);

    // Interrupt enables and out-of-window access
    busWrite(A_CFG, 32'h43);
    checkOutput("irq_txie_empty", {31'b0, irq}, 32'h1);
    busWrite(A_CFG, 32'h23);
    checkOutput("irq_rxie_empty", {31'b0, irq}, 32'h0);
    busWrite(A_CFG, 32'h03);
    busRead(BASE + 32'h14, v); checkOutput("out_of_window", v, 32'h0);

    // Reset in the middle of a frame
    monEnable = 0;
    busWrite(A_DIV, 32'd7);
    busWrite(A_TX, 32'h55);
    busRead(A_STAT, v); checkOutput("midframe_busy", {31'b0, v[16]}, 32'h1);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_midframe_ser_tx", {31'b0, ser_tx}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    busRead(A_STAT, v);
    checkOutput("reset_midframe_tx_count", {24'b0, v[7:0]}, 32'h0);
    checkOutput("reset_midframe_tx_busy", {31'b0, v[16]}, 32'h0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
